// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs fields and a signed immediate into a 32-bit word.
// Two-stage valid/ready pipeline with range/alignment checking and a saturating error counter.
module instr_encoder #(
  parameter int          CNT_W     = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [2:0]       out_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X
  } fmt_e;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_RANGE = 3'd1;
  localparam logic [2:0] ERR_ALIGN = 3'd2;
  localparam logic [2:0] ERR_ULOW  = 3'd3;
  localparam logic [2:0] ERR_OPC   = 3'd4;

  function automatic fmt_e decode_fmt(input logic [6:0] op);
    fmt_e f;
    case (op)
      7'b0110011:                         f = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111: f = FMT_I;
      7'b0100011:                         f = FMT_S;
      7'b1100011:                         f = FMT_B;
      7'b0110111, 7'b0010111:             f = FMT_U;
      7'b1101111:                         f = FMT_J;
      default:                            f = FMT_X;
    endcase
    return f;
  endfunction

  // Checks are ordered by priority: opcode, alignment, range, U low bits.
  function automatic logic [2:0] check_imm(input fmt_e f, input logic signed [31:0] imm);
    logic [2:0] e;
    e = ERR_NONE;
    if (f == FMT_X)
      e = ERR_OPC;
    else if ((f == FMT_B || f == FMT_J) && imm[0])
      e = ERR_ALIGN;
    else if ((f == FMT_I || f == FMT_S) && (imm[31:11] != {21{imm[31]}}))
      e = ERR_RANGE;
    else if (f == FMT_B && (imm[31:12] != {20{imm[31]}}))
      e = ERR_RANGE;
    else if (f == FMT_J && (imm[31:20] != {12{imm[31]}}))
      e = ERR_RANGE;
    else if (f == FMT_U && (imm[11:0] != 12'd0))
      e = ERR_ULOW;
    return e;
  endfunction

  function automatic logic [31:0] pack(
    input fmt_e              f,
    input logic [6:0]        op,
    input logic [4:0]        rd,
    input logic [4:0]        rs1,
    input logic [4:0]        rs2,
    input logic [2:0]        f3,
    input logic [6:0]        f7,
    input logic signed [31:0] imm
  );
    logic [31:0] w;
    case (f)
      FMT_R:   w = {f7, rs2, rs1, f3, rd, op};
      FMT_I:   w = {imm[11:0], rs1, f3, rd, op};
      FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      FMT_U:   w = {imm[31:12], rd, op};
      FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: w = NOP_INSTR;
    endcase
    return w;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv;

  logic [6:0]        opcode_p1;
  logic [4:0]        rd_p1, rs1_p1, rs2_p1;
  logic [2:0]        funct3_p1;
  logic [6:0]        funct7_p1;
  logic signed [31:0] imm_p1;
  fmt_e              fmt_p1;
  logic [2:0]        err_p1;

  logic [31:0]       instr_p1;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Stage 1: capture fields, decoded format and error code.
  always_ff @(posedge clk) begin
    if (in_valid && s1_adv) begin
      opcode_p1 <= in_opcode;
      rd_p1     <= in_rd;
      rs1_p1    <= in_rs1;
      rs2_p1    <= in_rs2;
      funct3_p1 <= in_funct3;
      funct7_p1 <= in_funct7;
      imm_p1    <= in_imm;
      fmt_p1    <= decode_fmt(in_opcode);
      err_p1    <= check_imm(decode_fmt(in_opcode), in_imm);
    end
  end

  assign instr_p1 = (err_p1 != ERR_NONE) ? NOP_INSTR :
                    pack(fmt_p1, opcode_p1, rd_p1, rs1_p1, rs2_p1, funct3_p1, funct7_p1, imm_p1);

  // Stage 2: packed word held stable while downstream stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_instr <= '0;
      out_err   <= '0;
      err_cnt   <= '0;
    end else begin
      if (s1_adv)
        s1_valid <= in_valid;
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_instr <= instr_p1;
          out_err   <= err_p1;
        end
      end
      if (err_clr)
        err_cnt <= '0;
      else if (s2_valid && out_ready && out_err != ERR_NONE)
        err_cnt <= sat_inc(err_cnt);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: vector table, backpressure, error counter and reset sequences.
// A second instance with a 2-bit counter shares all inputs to exercise saturation.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready_s;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid, out_valid_s;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr, out_instr_s;
  logic [2:0]  out_err, out_err_s;
  logic        err_clr = 1'b0;
  logic [15:0] err_cnt;
  logic [1:0]  err_cnt_s;

  always #5 clk = ~clk;

  instr_encoder #(.CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .err_clr(err_clr), .err_cnt(err_cnt)
  );

  instr_encoder #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_instr(out_instr_s),
    .out_err(out_err_s), .err_clr(err_clr), .err_cnt(err_cnt_s)
  );

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic [2:0]  exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   popped = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Scoreboard: a word presented with out_ready high transfers on the next edge.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got 0x%08h expected none", out_instr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        popped++;
        check("sb_instr", out_instr, e.instr);
        check("sb_err", {29'd0, out_err}, {29'd0, e.err});
      end
    end
  end

  task automatic drive(input vec_t v);
    in_valid  = 1'b1;
    in_opcode = v.op;
    in_rd     = v.rd;
    in_rs1    = v.rs1;
    in_rs2    = v.rs2;
    in_funct3 = v.f3;
    in_funct7 = v.f7;
    in_imm    = v.imm;
  endtask

  task automatic send(input vec_t v);
    int n;
    exp_t e;
    n = 0;
    drive(v);
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%0d expected 1", in_ready);
    end else begin
      e.instr = v.exp_instr;
      e.err   = v.exp_err;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: pending=%0d expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[8];
  vec_t errv[5];
  vec_t bp[4];

  initial begin
    logic [31:0] held;
    int n;

    vecs[0] = '{7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 3'd0};
    vecs[1] = '{7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,         32'h0020_A423, 3'd0};
    vecs[2] = '{7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 3'd0};
    vecs[3] = '{7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,      32'h0010_00EF, 3'd0};
    vecs[4] = '{7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 3'd0};
    vecs[5] = '{7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,      32'h0000_0013, 3'd1};
    vecs[6] = '{7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,         32'h0000_0013, 3'd2};
    vecs[7] = '{7'b1111111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,         32'h0000_0013, 3'd4};

    errv[0] = vecs[5];
    errv[1] = vecs[6];
    errv[2] = vecs[7];
    errv[3] = '{7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h0000_0013, 3'd3};
    errv[4] = '{7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096,      32'h0000_0013, 3'd1};

    bp[0] = '{7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,           32'h0020_81B3, 3'd0};
    bp[1] = '{7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800,   32'h8000_0093, 3'd0};
    bp[2] = vecs[1];
    bp[3] = vecs[4];

    // Reset state
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_err", {29'd0, out_err}, 32'd0);
    check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Vector table, back to back
    for (int i = 0; i < 8; i++) send(vecs[i]);
    drain();
    check("err_cnt_after_table", {16'd0, err_cnt}, 32'd3);

    // Backpressure: two accepts fill the pipe, then in_ready drops
    out_ready = 1'b0;
    send(bp[0]);
    send(bp[1]);
    drive(bp[2]);
    @(negedge clk);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    held = out_instr;
    check("bp_head_word", held, bp[0].exp_instr);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_instr_stable", out_instr, held);
      check("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    popped = 0;
    send(bp[2]);
    send(bp[3]);
    drain();
    check("bp_pop_count", popped, 32'd4);

    // err_clr coinciding with an accepted error word
    out_ready = 1'b0;
    send(vecs[5]);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("clr_word_ready", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    err_clr   = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("clr_wins", {16'd0, err_cnt}, 32'd0);
    check("clr_wins_sat", {30'd0, err_cnt_s}, 32'd0);

    // Saturation of the 2-bit counter
    for (int i = 0; i < 5; i++) send(errv[i]);
    drain();
    check("err_cnt_five", {16'd0, err_cnt}, 32'd5);
    check("err_cnt_sat", {30'd0, err_cnt_s}, 32'd3);

    // Reset with both stages full
    out_ready = 1'b0;
    send(vecs[0]);
    send(vecs[2]);
    @(negedge clk);
    check("full_in_ready_low", {31'd0, in_ready}, 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    sb.delete();
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_err_cnt", {16'd0, err_cnt}, 32'd0);
    check("arst_out_instr", out_instr, 32'd0);
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    popped = 0;
    send(vecs[3]);
    drain();
    check("post_rst_pop_count", popped, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: time=%0t expected finish", $time);
    $fatal(1);
  end

endmodule
